// File: rtl/core0_pkg.sv
// Shared types and constants for the core0 datapath.
// FAULT state exists only when INSTR_FETCH_ALIGN_CHECK_EN is defined.
package core0_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        ,
        S_FAULT = 3'd4
`endif
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, one outstanding imem read, valid/ready to decode.
// Define INSTR_FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets (fetch_fault).
module instr_fetch
    import core0_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    ,
    output logic            fetch_fault
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_pc_q;
    logic            capture;
    logic            in_fault;
    logic            misaligned;
    logic [XLEN-1:0] redir_pc;

    assign redir_pc = {pc_target[XLEN-1:2], 2'b00};

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    assign in_fault   = (state_q == S_FAULT);
    assign misaligned = |pc_target[1:0];
    assign fetch_fault = in_fault;
`else
    logic unused_target_lsbs;
    assign unused_target_lsbs = &{1'b0, pc_target[1:0]};
    assign in_fault   = 1'b0;
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        capture = 1'b0;

        unique case (state_q)
            S_REQ: begin
                if (imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = S_HOLD;
                    capture = 1'b1;
                    pc_d    = pc_q + XLEN'(INSTR_BYTES);
                end
            end
            S_HOLD: begin
                if (instr_ready) state_d = S_REQ;
            end
            S_DRAIN: begin
                if (imem_rsp_valid) state_d = S_REQ;
            end
            default: ;
        endcase

        // A redirect wins over everything; any in-flight response gets drained.
        if (pc_src && !in_fault) begin
            capture = 1'b0;
            pc_d    = redir_pc;
            unique case (state_q)
                S_REQ:   state_d = imem_req_ready ? S_DRAIN : S_REQ;
                S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
                S_HOLD:  state_d = S_REQ;
                S_DRAIN: state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
                default: ;
            endcase
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
            if (misaligned) state_d = S_FAULT;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (capture) begin
                instr_q    <= imem_rsp_data;
                instr_pc_q <= pc_q;
            end
        end
    end

    assign imem_req_valid = rst_n && (state_q == S_REQ);
    assign imem_req_addr  = {pc_q[XLEN-1:2], 2'b00};
    assign instr_valid    = (state_q == S_HOLD);
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: request and instruction queues checked by monitors.
// Covers reset, hold, redirects in WAIT/REQ, PC wrap and misaligned targets.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        pc_src;
    logic [31:0] pc_target;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ins_t;

    logic [31:0] exp_req[$];
    ins_t        exp_ins[$];

    instr_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .pc_src         (pc_src),
        .pc_target      (pc_target)
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        ,
        .fetch_fault    (fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Memory model: fixed latency (mem_lat >= 1), data = ~addr except 0x100
    int          mem_lat = 1;
    logic        acc_seen = 1'b0;
    logic [31:0] acc_addr = '0;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr = '0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'h0050_0093 : ~a;
    endfunction

    always @(negedge clk) begin
        acc_seen = rst_n && imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
    end

    always @(posedge clk) begin
        imem_rsp_valid <= 1'b0;
        if (!rst_n) begin
            pend <= 1'b0;
        end else begin
            if (pend) begin
                if (cnt == 0) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= mem_data(pend_addr);
                    pend <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (acc_seen) begin
                if (mem_lat == 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= mem_data(acc_addr);
                end else begin
                    pend      <= 1'b1;
                    cnt       <= mem_lat - 2;
                    pend_addr <= acc_addr;
                end
            end
        end
    end

    // Monitors: pop expectations on every accepted request / consumed instruction
    always @(negedge clk) begin
        if (rst_n && imem_req_valid && imem_req_ready) begin
            if (exp_req.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got addr %08h expected none",
                         imem_req_addr);
            end else begin
                chk("req_addr", imem_req_addr, exp_req.pop_front());
            end
        end
        if (rst_n && instr_valid && instr_ready) begin
            if (exp_ins.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got pc %08h expected none",
                         instr_pc);
            end else begin
                ins_t e;
                e = exp_ins.pop_front();
                chk("instr", instr, e.ins);
                chk("instr_pc", instr_pc, e.pc);
            end
        end
    end

    task automatic wait_req(input logic [31:0] addr);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (imem_req_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_req timeout: got none expected %08h", addr);
        end else begin
            chk("wait_req_addr", imem_req_addr, addr);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        pc_src         = 1'b0;
        pc_target      = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        exp_req = '{32'h100, 32'h104, 32'h200, 32'h204, 32'h40, 32'h44,
                    32'hFFFF_FFFC, 32'h0};
        exp_ins.push_back('{pc: 32'h100, ins: 32'h0050_0093});
        exp_ins.push_back('{pc: 32'h200, ins: 32'hFFFF_FDFF});
        exp_ins.push_back('{pc: 32'h40, ins: 32'hFFFF_FFBF});
        exp_ins.push_back('{pc: 32'hFFFF_FFFC, ins: 32'h0000_0003});
        exp_ins.push_back('{pc: 32'h0, ins: 32'hFFFF_FFFF});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        chk("rst_fault", 32'(fetch_fault), 32'd0);
`endif
        rst_n = 1'b1;

        @(negedge clk);
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h100);
        repeat (2) @(negedge clk);
        chk("lat_instr_valid", 32'(instr_valid), 32'd1);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_instr", instr, 32'h0050_0093);
            chk("hold_pc", instr_pc, 32'h100);
            chk("hold_no_req", 32'(imem_req_valid), 32'd0);
        end

        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        mem_lat     = 4;
        repeat (2) @(negedge clk);
        chk("next_req_valid", 32'(imem_req_valid), 32'd1);
        chk("next_req_addr", imem_req_addr, 32'h104);

        // Redirect while in WAIT; the late response must be dropped
        @(posedge clk);
        #1;
        pc_src    = 1'b1;
        pc_target = 32'h200;
        mem_lat   = 1;
        @(posedge clk);
        #1;
        pc_src = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (imem_req_valid) begin
                    seen = 1'b1;
                    break;
                end
                chk("drain_no_instr", 32'(instr_valid), 32'd0);
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL drain timeout: got no req expected req 200");
            end else begin
                chk("drain_req_addr", imem_req_addr, 32'h200);
            end
        end

        // Redirect in the cycle the response arrives
        wait_req(32'h204);
        @(posedge clk);
        #1;
        pc_src    = 1'b1;
        pc_target = 32'h40;
        @(posedge clk);
        #1;
        pc_src = 1'b0;
        @(negedge clk);
        chk("rsp_redir_req", 32'(imem_req_valid), 32'd1);
        chk("rsp_redir_addr", imem_req_addr, 32'h40);
        chk("rsp_redir_valid", 32'(instr_valid), 32'd0);

        // Redirect from REQ with acceptance, to the top of the address space
        wait_req(32'h44);
        pc_src    = 1'b1;
        pc_target = 32'hFFFF_FFFC;
        @(posedge clk);
        #1;
        pc_src = 1'b0;
        wait_req(32'hFFFF_FFFC);
        wait_req(32'h0);
        @(posedge clk);
        #1;
        imem_req_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_req_valid", 32'(imem_req_valid), 32'd1);
        chk("stall_req_addr", imem_req_addr, 32'h4);

        // Misaligned redirect target, from REQ without acceptance
        pc_src    = 1'b1;
        pc_target = 32'h202;
        @(posedge clk);
        #1;
        pc_src = 1'b0;
        @(negedge clk);
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        chk("fault_set", 32'(fetch_fault), 32'd1);
        chk("fault_no_req", 32'(imem_req_valid), 32'd0);
        imem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("fault_sticky", 32'(fetch_fault), 32'd1);
            chk("fault_no_valid", 32'(instr_valid), 32'd0);
        end
        imem_req_ready = 1'b0;
`else
        chk("align_req_valid", 32'(imem_req_valid), 32'd1);
        chk("align_req_addr", imem_req_addr, 32'h200);
        exp_req.push_back(32'h200);
        exp_ins.push_back('{pc: 32'h200, ins: 32'hFFFF_FDFF});
        imem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        imem_req_ready = 1'b0;
`endif
        repeat (4) @(posedge clk);
        #1;

        // Mid-operation reset pulse
        rst_n = 1'b0;
        #1;
        chk("rst2_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst2_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst2_instr", instr, 32'h0);
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        chk("rst2_fault", 32'(fetch_fault), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_req_valid_after", 32'(imem_req_valid), 32'd1);
        chk("rst2_req_addr", imem_req_addr, 32'h100);

        chk("req_queue_empty", 32'(exp_req.size()), 32'd0);
        chk("ins_queue_empty", 32'(exp_ins.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
